// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master, one-slave arbiter for the 16-bit memory bus.
// Serialises accesses from master 0 (CPU) and master 1 (debug/DMA) onto a
// single slave using an IDLE -> XFER -> DONE sequence. An optional watchdog
// aborts transfers that the slave stalls for too long.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   mN_addr_i            master N address
//   mN_re_i / mN_we_i    master N read / write request (both high = write)
//   mN_wdata_i           master N write data
//   mN_rdata_o           master N read data (registered)
//   mN_needWait_o        master N stall (combinational)
//   s_addr_o             slave address (latched at grant)
//   s_re_o / s_we_o      slave read / write strobes (high only in XFER)
//   s_data_io            slave data bus, driven only during a write XFER
//   s_needWait_i         slave stall
//   grant_o              one-hot owner of the current transfer, 00 when idle
//   err_o                one-cycle pulse in DONE of an aborted transfer
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_re_i,
  input  logic              m0_we_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_needWait_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_re_i,
  input  logic              m1_we_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_needWait_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic              s_re_o,
  output logic              s_we_o,
  inout  wire logic [DATA_W-1:0] s_data_io,
  input  logic              s_needWait_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  // Last stalled-cycle count value before the watchdog fires.
  localparam logic [15:0] TmoLast = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_e            r_state, w_state_nxt;
  logic [1:0]        r_grant, w_grant_nxt;
  logic              r_last, w_last_nxt;     // 1: master 1 was granted last
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_we, w_we_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;
  logic              r_abort, w_abort_nxt;
  logic [DATA_W-1:0] r_rdata0, w_rdata0_nxt;
  logic [DATA_W-1:0] r_rdata1, w_rdata1_nxt;

  logic w_req0, w_req1, w_pick1, w_in_xfer, w_in_done;

  assign w_req0 = m0_re_i | m0_we_i;
  assign w_req1 = m1_re_i | m1_we_i;

  // Master 1 wins when alone, or on a round-robin tie when master 0 went last.
  assign w_pick1 = w_req1 & (~w_req0 | ((FIXED_PRIO == 0) & ~r_last));

  assign w_in_xfer = (r_state == StXfer);
  assign w_in_done = (r_state == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_cnt    <= 16'd0;
      r_abort  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_last   <= w_last_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_we     <= w_we_nxt;
      r_cnt    <= w_cnt_nxt;
      r_abort  <= w_abort_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_we_nxt     = r_we;
    w_cnt_nxt    = r_cnt;
    w_abort_nxt  = r_abort;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
    case (r_state)
      StIdle: begin
        if (w_req0 | w_req1) begin
          w_grant_nxt = w_pick1 ? 2'b10 : 2'b01;
          w_last_nxt  = w_pick1;
          w_addr_nxt  = w_pick1 ? m1_addr_i : m0_addr_i;
          w_wdata_nxt = w_pick1 ? m1_wdata_i : m0_wdata_i;
          w_we_nxt    = w_pick1 ? m1_we_i : m0_we_i;
          w_cnt_nxt   = 16'd0;
          w_abort_nxt = 1'b0;
          w_state_nxt = StXfer;
        end
      end
      StXfer: begin
        if (!s_needWait_i) begin
          if (!r_we) begin
            if (r_grant[1]) w_rdata1_nxt = s_data_io;
            else            w_rdata0_nxt = s_data_io;
          end
          w_state_nxt = StDone;
        end else if ((TIMEOUT != 0) && (r_cnt == TmoLast)) begin
          if (!r_we) begin
            if (r_grant[1]) w_rdata1_nxt = '1;
            else            w_rdata0_nxt = '1;
          end
          w_abort_nxt = 1'b1;
          w_state_nxt = StDone;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      StDone: begin
        w_grant_nxt = 2'b00;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign s_addr_o  = r_addr;
  assign s_re_o    = w_in_xfer & ~r_we;
  assign s_we_o    = w_in_xfer & r_we;
  assign s_data_io = s_we_o ? r_wdata : {DATA_W{1'bz}};
  assign grant_o   = r_grant;
  assign err_o     = w_in_done & r_abort;

  assign m0_rdata_o = r_rdata0;
  assign m1_rdata_o = r_rdata1;

  // A requester is released only in the DONE cycle of its own transfer.
  assign m0_needWait_o = w_req0 & ~(w_in_done & r_grant[0]);
  assign m1_needWait_o = w_req1 & ~(w_in_done & r_grant[1]);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata, slv_rdata;
  logic        m0_re, m0_we, m1_re, m1_we, s_nw;

  // Round-robin instance with TIMEOUT=8
  logic [15:0] r_m0_rd, r_m1_rd, r_saddr;
  logic        r_m0_nw, r_m1_nw, r_sre, r_swe, r_err;
  logic [1:0]  r_gnt;
  wire  [15:0] r_sdata;
  // Fixed-priority instance, no timeout
  logic [15:0] f_m0_rd, f_m1_rd, f_saddr;
  logic        f_m0_nw, f_m1_nw, f_sre, f_swe, f_err;
  logic [1:0]  f_gnt;
  wire  [15:0] f_sdata;

  // Behavioural slave: drives read data only while a read strobe is up.
  assign r_sdata = r_sre ? slv_rdata : 16'hzzzz;
  assign f_sdata = f_sre ? slv_rdata : 16'hzzzz;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(0), .TIMEOUT(8)) u_rr (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr), .m0_re_i(m0_re), .m0_we_i(m0_we), .m0_wdata_i(m0_wdata),
    .m0_rdata_o(r_m0_rd), .m0_needWait_o(r_m0_nw),
    .m1_addr_i(m1_addr), .m1_re_i(m1_re), .m1_we_i(m1_we), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(r_m1_rd), .m1_needWait_o(r_m1_nw),
    .s_addr_o(r_saddr), .s_re_o(r_sre), .s_we_o(r_swe), .s_data_io(r_sdata),
    .s_needWait_i(s_nw), .grant_o(r_gnt), .err_o(r_err)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1), .TIMEOUT(0)) u_fp (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr), .m0_re_i(m0_re), .m0_we_i(m0_we), .m0_wdata_i(m0_wdata),
    .m0_rdata_o(f_m0_rd), .m0_needWait_o(f_m0_nw),
    .m1_addr_i(m1_addr), .m1_re_i(m1_re), .m1_we_i(m1_we), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(f_m1_rd), .m1_needWait_o(f_m1_nw),
    .s_addr_o(f_saddr), .s_re_o(f_sre), .s_we_o(f_swe), .s_data_io(f_sdata),
    .s_needWait_i(s_nw), .grant_o(f_gnt), .err_o(f_err)
  );

  // Transaction-level reference: who owns the bus, whether the transfer has
  // finished (the DONE cycle), how long it has stalled, and what each master
  // has read back.
  typedef struct packed {
    int               owner;   // -1 when no transfer is in flight
    bit               done;
    bit               abort;
    bit               wr;
    int               stalls;
    int               last;
    logic [15:0]      addr;
    logic [15:0]      wdata;
    logic [1:0][15:0] rd;
  } mdl_t;

  mdl_t mr, mf;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.owner = -1; m.done = 1'b0; m.abort = 1'b0; m.wr = 1'b0;
    m.stalls = 0; m.last = 1; m.addr = 16'h0; m.wdata = 16'h0; m.rd = '0;
    return m;
  endfunction

  // Model state after the coming clock edge, given the inputs now applied.
  function automatic mdl_t mdl_next(mdl_t m, bit fixed, int tmo);
    bit q0 = m0_re | m0_we;
    bit q1 = m1_re | m1_we;
    if (rst) return mdl_reset();
    if (m.owner < 0) begin
      if (q0 || q1) begin
        int w;
        if (q0 && q1) w = fixed ? 0 : 1 - m.last;
        else          w = q0 ? 0 : 1;
        m.owner  = w;
        m.last   = w;
        m.wr     = (w == 1) ? m1_we : m0_we;
        m.addr   = (w == 1) ? m1_addr : m0_addr;
        m.wdata  = (w == 1) ? m1_wdata : m0_wdata;
        m.stalls = 0;
        m.abort  = 1'b0;
      end
    end else if (!m.done) begin
      if (!s_nw) begin
        if (!m.wr) m.rd[m.owner] = slv_rdata;
        m.done = 1'b1;
      end else begin
        m.stalls++;
        if (tmo != 0 && m.stalls == tmo) begin
          if (!m.wr) m.rd[m.owner] = 16'hFFFF;
          m.abort = 1'b1;
          m.done  = 1'b1;
        end
      end
    end else begin
      m.owner = -1;
      m.done  = 1'b0;
      m.abort = 1'b0;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string p, input mdl_t m, input logic [1:0] gnt,
                           input logic sre, input logic swe, input logic err,
                           input logic nw0, input logic nw1,
                           input logic [15:0] rd0, input logic [15:0] rd1,
                           input logic [15:0] saddr, input logic [15:0] sdata);
    bit q0 = m0_re | m0_we;
    bit q1 = m1_re | m1_we;
    bit xf = (m.owner >= 0) && !m.done;
    chk({p, ".grant"}, 16'(gnt), (m.owner < 0) ? 16'd0 : 16'(1 << m.owner));
    chk({p, ".s_re"}, 16'(sre), 16'(xf && !m.wr));
    chk({p, ".s_we"}, 16'(swe), 16'(xf && m.wr));
    chk({p, ".err"}, 16'(err), 16'(m.done && m.abort));
    chk({p, ".nw0"}, 16'(nw0), 16'(q0 && !(m.done && m.owner == 0)));
    chk({p, ".nw1"}, 16'(nw1), 16'(q1 && !(m.done && m.owner == 1)));
    chk({p, ".rd0"}, rd0, m.rd[0]);
    chk({p, ".rd1"}, rd1, m.rd[1]);
    if (xf) chk({p, ".s_addr"}, saddr, m.addr);
    if (xf && m.wr) chk({p, ".s_data"}, sdata, m.wdata);
  endtask

  task automatic settle();
    #1;
    check_dut("rr", mr, r_gnt, r_sre, r_swe, r_err, r_m0_nw, r_m1_nw, r_m0_rd, r_m1_rd,
              r_saddr, r_sdata);
    check_dut("fp", mf, f_gnt, f_sre, f_swe, f_err, f_m0_nw, f_m1_nw, f_m0_rd, f_m1_rd,
              f_saddr, f_sdata);
  endtask

  task automatic adv();
    mr = mdl_next(mr, 1'b0, 8);
    mf = mdl_next(mf, 1'b1, 0);
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int unsigned exp_g  [8] = '{0, 1, 1, 0, 2, 2, 0, 1};
  int unsigned exp_nw1[8] = '{1, 1, 1, 1, 1, 0, 1, 1};
  int stall_run = 0;

  initial begin
    rst = 1'b1;
    m0_addr = 16'h0; m1_addr = 16'h0; m0_wdata = 16'h0; m1_wdata = 16'h0;
    m0_re = 1'b0; m0_we = 1'b0; m1_re = 1'b0; m1_we = 1'b0;
    s_nw = 1'b0; slv_rdata = 16'h0;
    repeat (3) @(negedge clk);
    mr = mdl_reset();
    mf = mdl_reset();
    rst = 1'b0;
    step();

    // Zero-wait read by master 0.
    m0_re = 1'b1; m0_addr = 16'h0010; slv_rdata = 16'h1234;
    step();
    settle();
    chk("t1.s_re", 16'(r_sre), 16'd1);
    chk("t1.s_addr", r_saddr, 16'h0010);
    chk("t1.grant", 16'(r_gnt), 16'd1);
    adv();
    settle();
    chk("t1.rdata", r_m0_rd, 16'h1234);
    chk("t1.nw0", 16'(r_m0_nw), 16'd0);
    m0_re = 1'b0;
    adv();
    step();

    // Round-robin tie: m0 read, m1 write, both held.
    do_reset();
    m0_re = 1'b1; m0_addr = 16'h0030; slv_rdata = 16'h0C0C;
    m1_we = 1'b1; m1_addr = 16'h0020; m1_wdata = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("t2.grant", 16'(r_gnt), 16'(exp_g[i]));
      chk("t2.nw1", 16'(r_m1_nw), 16'(exp_nw1[i]));
      if (i == 4) chk("t2.s_data", r_sdata, 16'hBEEF);
      adv();
    end
    m0_re = 1'b0; m1_we = 1'b0;
    step();
    step();

    // Fixed priority: m1 starves until m0 lets go.
    do_reset();
    m0_re = 1'b1; m1_re = 1'b1; m0_addr = 16'h0100; m1_addr = 16'h0200;
    slv_rdata = 16'h1111;
    for (int i = 0; i < 11; i++) begin
      settle();
      if (i < 10) chk("t3.no_m1", 16'(f_gnt[1]), 16'd0);
      else        chk("t3.m1_won", 16'(f_gnt), 16'd2);
      if (i == 8) m0_re = 1'b0;
      adv();
    end
    m1_re = 1'b0;
    step();
    step();

    // Three slave wait cycles on an m1 read.
    m1_re = 1'b1; m1_addr = 16'h0300; slv_rdata = 16'h5A5A;
    for (int i = 0; i < 6; i++) begin
      s_nw = (i < 4);
      settle();
      chk("t4.nw0", 16'(r_m0_nw), 16'd0);
      chk("t4.nw1", 16'(r_m1_nw), (i == 5) ? 16'd0 : 16'd1);
      if (i == 5) begin
        chk("t4.rdata", r_m1_rd, 16'h5A5A);
        m1_re = 1'b0;
      end
      adv();
    end
    step();

    // Slave stuck: the TIMEOUT=8 instance aborts, then serves the next read.
    for (int i = 0; i < 13; i++) begin
      if (i == 0) begin m0_re = 1'b1; m0_addr = 16'h0040; s_nw = 1'b1; end
      if (i == 10) begin m0_re = 1'b1; s_nw = 1'b0; slv_rdata = 16'h7777; end
      settle();
      if (i >= 1 && i <= 8) begin
        chk("t5.s_re", 16'(r_sre), 16'd1);
        chk("t5.err_lo", 16'(r_err), 16'd0);
      end
      if (i == 9) begin
        chk("t5.err_hi", 16'(r_err), 16'd1);
        chk("t5.s_re_done", 16'(r_sre), 16'd0);
        chk("t5.rd_ones", r_m0_rd, 16'hFFFF);
        m0_re = 1'b0;
      end
      if (i == 10) chk("t5.err_end", 16'(r_err), 16'd0);
      if (i == 12) begin
        chk("t5.rd_next", r_m0_rd, 16'h7777);
        m0_re = 1'b0;
      end
      adv();
    end
    step();
    step();

    // Reset in the second cycle of a waited read.
    m0_re = 1'b1; m0_addr = 16'h0050; s_nw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rst = (i == 2);
      if (i == 3) begin s_nw = 1'b0; m1_re = 1'b1; slv_rdata = 16'h2468; end
      settle();
      if (i == 2) chk("t6.pre_rd", 16'(r_m0_rd == 16'h0), 16'd0);
      if (i == 3) begin
        chk("t6.s_re", 16'(r_sre), 16'd0);
        chk("t6.grant", 16'(r_gnt), 16'd0);
        chk("t6.rd0", r_m0_rd, 16'h0);
        chk("t6.nw0", 16'(r_m0_nw), 16'd1);
      end
      if (i == 4) chk("t6.m0_wins", 16'(r_gnt), 16'd1);
      adv();
    end
    rst = 1'b0;

    // Randomised traffic, including withdrawn requests and sticky stalls.
    for (int c = 0; c < 1500; c++) begin
      m0_re = ($urandom_range(2) == 0); m0_we = ($urandom_range(3) == 0);
      m1_re = ($urandom_range(2) == 0); m1_we = ($urandom_range(3) == 0);
      m0_addr = 16'($urandom); m1_addr = 16'($urandom);
      m0_wdata = 16'($urandom); m1_wdata = 16'($urandom);
      slv_rdata = 16'($urandom);
      if (stall_run > 0) begin
        s_nw = 1'b1;
        stall_run--;
      end else if ($urandom_range(15) == 0) begin
        stall_run = int'($urandom_range(12, 4));
        s_nw = 1'b1;
      end else begin
        s_nw = ($urandom_range(1) == 1);
      end
      rst = ($urandom_range(199) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
